// File: rtl/sequential_divider.sv
// Iterative signed divider: restoring algorithm, one quotient bit per clock.
// Truncating semantics (quotient toward zero, remainder takes dividend sign).
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] vmag;
    logic             q_neg;
    logic             r_neg;
    logic             zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand magnitudes and the widened trial subtraction for one step.
    // The most-negative value's magnitude is exact as an unsigned number.
    always_comb begin
        a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag   = divisor[WIDTH-1] ? -divisor : divisor;
        shifted = {rem, qreg[WIDTH-1]};
        trial   = shifted - {1'b0, vmag};
    end

    // Control FSM, datapath iteration and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            qreg        <= '0;
            rem         <= '0;
            vmag        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        qreg  <= a_mag;
                        vmag  <= b_mag;
                        rem   <= '0;
                        q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg <= dividend[WIDTH-1];
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            zero  <= 1'b1;
                            state <= FIX;
                        end else begin
                            zero  <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A borrow out of the top bit means the trial went negative.
                    qreg <= {qreg[WIDTH-2:0], ~trial[WIDTH]};
                    rem  <= trial[WIDTH] ? shifted[WIDTH-1:0]
                                         : trial[WIDTH-1:0];
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero) begin
                        // qreg still holds |dividend|; re-sign to return it as given.
                        quotient    <= '1;
                        remainder   <= r_neg ? -qreg : qreg;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_neg ? -qreg : qreg;
                        remainder   <= r_neg ? -rem : rem;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (WIDTH=32).
// Inputs change and outputs are sampled on the falling edge.
module tb_sequential_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;
    int lat;
    int pulses;

    sequential_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: request, then wait for done (bounded).
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        dividend = 32'h5a5a_5a5a;
        divisor  = 32'h0000_0003;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic edbz,
                         input int elat);
        longint prod;
        int n;
        launch(a, b, n);
        check({tag, ".lat"}, n, elat);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        if (!edbz) begin
            prod = longint'($signed(quotient)) * longint'($signed(b))
                   + longint'($signed(remainder));
            check({tag, ".qb+r"}, prod[31:0], a);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.q", quotient, 32'd0);
        check("rst.r", remainder, 32'd0);
        check("rst.flags", {29'b0, done, busy, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with latency, busy and one-cycle-wide done checks
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("p.busy", {31'b0, busy}, 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
        check("p.lat", lat, 33);
        check("p.q", quotient, 32'd14);
        check("p.r", remainder, 32'd2);
        check("p.dbz", {31'b0, div_by_zero}, 32'd0);
        check("p.busy_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("p.done_w", {31'b0, done}, 32'd0);

        do_op("nm", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 33);
        do_op("mn", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 33);
        do_op("nn", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 33);
        do_op("ovf", 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'd0,
              1'b0, 33);
        do_op("small", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 33);
        do_op("zero", 32'd0, -32'sd5, 32'd0, 32'd0, 1'b0, 33);
        do_op("mneg1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
        do_op("dz", 32'd5, 32'd0, 32'hffff_ffff, 32'd5, 1'b1, 1);
        do_op("dzn", -32'sd9, 32'd0, 32'hffff_ffff, -32'sd9, 1'b1, 1);
        do_op("after", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // start held high through the op with changing operands
        @(negedge clk);
        start = 1'b1; dividend = 32'd20; divisor = 32'd3;
        pulses = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            dividend = dividend + 32'd17;
            divisor  = divisor + 32'd1;
        end while (!done && lat < 100);
        start = 1'b0;
        pulses = done ? 1 : 0;
        check("hold.q", quotient, 32'd6);
        check("hold.r", remainder, 32'd2);
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("hold.pulses", pulses, 1);

        // back-to-back: new start during the done cycle
        launch(32'd77, 32'd10, lat);
        check("b2b.q1", quotient, 32'd7);
        launch(32'd50, 32'd8, lat);
        check("b2b.lat", lat, 33);
        check("b2b.q", quotient, 32'd6);
        check("b2b.r", remainder, 32'd2);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("ar.busy_pre", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar.q", quotient, 32'd0);
        check("ar.r", remainder, 32'd0);
        check("ar.flags", {29'b0, done, busy, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ar.no_done", pulses, 0);
        do_op("ar.after", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
